// File: rtl/store_unit.sv
// Write-side memory stage: narrows SB/SH/SW register data onto byte lanes and
// performs one valid/ready write to data memory, reporting done or an error code.
module store_unit #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_size,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_data,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [1:0]  err_code
);

  typedef enum logic [1:0] {IDLE, MEM, RESP, FAIL} state_t;

  localparam logic [7:0] LIMIT = 8'(TIMEOUT);

  localparam logic [1:0] CODE_MISALIGN = 2'b01;
  localparam logic [1:0] CODE_SIZE     = 2'b10;
  localparam logic [1:0] CODE_TIMEOUT  = 2'b11;

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d, cnt_inc;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  be_q, be_d;
  logic [1:0]  code_q, code_d;

  assign cnt_inc = cnt_q + 8'd1;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    code_d  = code_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          addr_d = {req_addr[31:2], 2'b00};
          cnt_d  = 8'd0;
          case (req_size)
            2'b00: begin
              wdata_d = {4{req_data[7:0]}};
              be_d    = 4'b0001 << req_addr[1:0];
              state_d = MEM;
            end
            2'b01: begin
              wdata_d = {2{req_data[15:0]}};
              be_d    = req_addr[1] ? 4'b1100 : 4'b0011;
              if (req_addr[0]) begin
                code_d  = CODE_MISALIGN;
                state_d = FAIL;
              end else begin
                state_d = MEM;
              end
            end
            2'b10: begin
              wdata_d = req_data;
              be_d    = 4'b1111;
              if (req_addr[1:0] != 2'b00) begin
                code_d  = CODE_MISALIGN;
                state_d = FAIL;
              end else begin
                state_d = MEM;
              end
            end
            default: begin
              code_d  = CODE_SIZE;
              state_d = FAIL;
            end
          endcase
        end
      end
      MEM: begin
        // A ready arriving in the expiry cycle still completes the write.
        if (mem_ready) begin
          state_d = RESP;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc == LIMIT) begin
            code_d  = CODE_TIMEOUT;
            state_d = FAIL;
          end
        end
      end
      RESP:    state_d = IDLE;
      FAIL:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      be_q    <= 4'd0;
      code_q  <= 2'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      code_q  <= code_d;
    end
  end

  // Outputs depend only on registered state, never on req_* or mem_ready.
  assign req_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign mem_valid = (state_q == MEM);
  assign done      = (state_q == RESP);
  assign err       = (state_q == FAIL);
  assign err_code  = (state_q == FAIL) ? code_q : 2'b00;
  assign mem_addr  = mem_valid ? addr_q  : 32'd0;
  assign mem_wdata = mem_valid ? wdata_q : 32'd0;
  assign mem_be    = mem_valid ? be_q    : 4'd0;

endmodule

// File: tb/tb_store_unit.sv
// Self-checking bench for store_unit: one instance at the default timeout and one
// with TIMEOUT=4, compared against a lane/enable/timing model of the store rules.
module tb_store_unit;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        sel = 1'b0;
  logic        req_valid = 1'b0;
  logic        mem_ready = 1'b0;
  logic [1:0]  req_size = 2'd0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_data = 32'd0;

  logic        a_req_ready, a_mem_valid, a_busy, a_done, a_err;
  logic [31:0] a_mem_addr, a_mem_wdata;
  logic [3:0]  a_mem_be;
  logic [1:0]  a_err_code;
  logic        b_req_ready, b_mem_valid, b_busy, b_done, b_err;
  logic [31:0] b_mem_addr, b_mem_wdata;
  logic [3:0]  b_mem_be;
  logic [1:0]  b_err_code;

  store_unit u_a (
    .clk(clk), .rst(rst),
    .req_valid(req_valid & ~sel), .req_ready(a_req_ready),
    .req_size(req_size), .req_addr(req_addr), .req_data(req_data),
    .mem_valid(a_mem_valid), .mem_ready(mem_ready & ~sel),
    .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata), .mem_be(a_mem_be),
    .busy(a_busy), .done(a_done), .err(a_err), .err_code(a_err_code)
  );

  store_unit #(.TIMEOUT(4)) u_b (
    .clk(clk), .rst(rst),
    .req_valid(req_valid & sel), .req_ready(b_req_ready),
    .req_size(req_size), .req_addr(req_addr), .req_data(req_data),
    .mem_valid(b_mem_valid), .mem_ready(mem_ready & sel),
    .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata), .mem_be(b_mem_be),
    .busy(b_busy), .done(b_done), .err(b_err), .err_code(b_err_code)
  );

  logic        s_req_ready, s_mem_valid, s_busy, s_done, s_err;
  logic [31:0] s_mem_addr, s_mem_wdata;
  logic [3:0]  s_mem_be;
  logic [1:0]  s_err_code;
  assign s_req_ready = sel ? b_req_ready : a_req_ready;
  assign s_mem_valid = sel ? b_mem_valid : a_mem_valid;
  assign s_busy      = sel ? b_busy      : a_busy;
  assign s_done      = sel ? b_done      : a_done;
  assign s_err       = sel ? b_err       : a_err;
  assign s_err_code  = sel ? b_err_code  : a_err_code;
  assign s_mem_addr  = sel ? b_mem_addr  : a_mem_addr;
  assign s_mem_wdata = sel ? b_mem_wdata : a_mem_wdata;
  assign s_mem_be    = sel ? b_mem_be    : a_mem_be;

  int checks = 0;
  int passed = 0;

  // What one transaction looked like from outside the DUT.
  int          obs_nmv, obs_ndone, obs_nerr, obs_ev_lat, obs_idle_lat, obs_glitch, obs_unstable;
  logic [1:0]  obs_code;
  logic [31:0] obs_addr, obs_wdata;
  logic [3:0]  obs_be;

  // Store rules: lane data, enables, and whether the request is legal.
  function automatic void model(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d,
                                output bit ok, output logic [1:0] code, output logic [31:0] addr,
                                output logic [31:0] wd, output logic [3:0] be);
    int lane;
    lane = int'(a % 4);
    addr = a - (a % 4);
    ok   = 1'b1;
    code = 2'd0;
    wd   = 32'd0;
    be   = 4'd0;
    if (sz == 2'd3) begin
      ok = 1'b0; code = 2'd2;
    end else if ((sz == 2'd1 && (a % 2) != 0) || (sz == 2'd2 && lane != 0)) begin
      ok = 1'b0; code = 2'd1;
    end else if (sz == 2'd0) begin
      wd = (d & 32'hFF) * 32'h0101_0101;
      be = 4'(1 << lane);
    end else if (sz == 2'd1) begin
      wd = (d & 32'hFFFF) * 32'h0001_0001;
      be = (lane >= 2) ? 4'b1100 : 4'b0011;
    end else begin
      wd = d;
      be = 4'b1111;
    end
  endfunction

  // Expected {mem cycles, dones, errs, event cycle, code, idle cycle}, cycles counted from accept.
  function automatic logic [57:0] exp_timing(input bit ok, input logic [1:0] code, input int delay, input int tmo);
    if (!ok)
      return {16'd0, 4'd0, 4'd1, 16'd1, code, 16'd2};
    else if (delay < tmo)
      return {16'(delay + 1), 4'd1, 4'd0, 16'(delay + 2), 2'd0, 16'(delay + 3)};
    else
      return {16'(tmo), 4'd0, 4'd1, 16'(tmo + 1), 2'd3, 16'(tmo + 2)};
  endfunction

  function automatic logic [57:0] obs_timing();
    return {16'(obs_nmv), 4'(obs_ndone), 4'(obs_nerr), 16'(obs_ev_lat), obs_code, 16'(obs_idle_lat)};
  endfunction

  // Drive one request from IDLE, respond with mem_ready after 'delay' wait cycles, and record outputs.
  task automatic run_store(input logic which, input logic [1:0] sz, input logic [31:0] a,
                           input logic [31:0] d, input int delay, input bit hold);
    sel = which;
    mem_ready = 1'b0;
    req_size = sz; req_addr = a; req_data = d; req_valid = 1'b1;
    obs_nmv = 0; obs_ndone = 0; obs_nerr = 0; obs_ev_lat = 0; obs_idle_lat = 0;
    obs_glitch = 0; obs_unstable = 0; obs_code = 2'd0;
    obs_addr = 32'd0; obs_wdata = 32'd0; obs_be = 4'd0;
    @(posedge clk); #1;
    if (!hold) req_valid = 1'b0;
    req_size = 2'($urandom); req_addr = $urandom; req_data = $urandom;
    for (int cyc = 1; cyc <= 300; cyc++) begin
      if (s_mem_valid) begin
        obs_nmv++;
        if (obs_nmv == 1) begin
          obs_addr = s_mem_addr; obs_wdata = s_mem_wdata; obs_be = s_mem_be;
        end else if ({s_mem_addr, s_mem_wdata, s_mem_be} !== {obs_addr, obs_wdata, obs_be}) begin
          obs_unstable++;
        end
      end else if ({s_mem_addr, s_mem_wdata, s_mem_be} !== 68'd0) begin
        obs_glitch++;
      end
      if (s_busy === s_req_ready) obs_glitch++;
      if (!s_err && s_err_code !== 2'd0) obs_glitch++;
      if (s_done) begin obs_ndone++; obs_ev_lat = cyc; end
      if (s_err) begin obs_nerr++; obs_ev_lat = cyc; obs_code = s_err_code; end
      if (s_req_ready) begin obs_idle_lat = cyc; break; end
      mem_ready = s_mem_valid && (obs_nmv > delay);
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    mem_ready = 1'b0;
    $display("txn u=%0d size=%0d addr=%h data=%h delay=%0d : mem=%0d done=%0d err=%0d code=%0d idle@%0d",
             which, sz, a, d, delay, obs_nmv, obs_ndone, obs_nerr, obs_code, obs_idle_lat);
  endtask

  task automatic test_reset();
    sel = 1'b0;
    checks++;
    if ({s_req_ready, s_busy, s_mem_valid, s_done, s_err, s_err_code} !== 7'b100_0000)
      $display("FAIL reset_ctrl: got %b expected 1000000", {s_req_ready, s_busy, s_mem_valid, s_done, s_err, s_err_code});
    else passed++;
    checks++;
    if ({s_mem_addr, s_mem_wdata, s_mem_be} !== 68'd0)
      $display("FAIL reset_bus: got %h expected 0", {s_mem_addr, s_mem_wdata, s_mem_be});
    else passed++;
    checks++;
    if ({b_req_ready, b_busy, b_mem_valid} !== 3'b100)
      $display("FAIL reset_b: got %b expected 100", {b_req_ready, b_busy, b_mem_valid});
    else passed++;
  endtask

  task automatic test_directed();
    logic [1:0]  t_sz [3] = '{2'd0, 2'd1, 2'd2};
    logic [31:0] t_a  [3] = '{32'h0000_1003, 32'h0000_2002, 32'h0000_2004};
    logic [31:0] t_d  [3] = '{32'h1234_5678, 32'hAAAA_8001, 32'hDEAD_BEEF};
    logic [31:0] t_ma [3] = '{32'h0000_1000, 32'h0000_2000, 32'h0000_2004};
    logic [31:0] t_wd [3] = '{32'h7878_7878, 32'h8001_8001, 32'hDEAD_BEEF};
    logic [3:0]  t_be [3] = '{4'b1000, 4'b1100, 4'b1111};
    for (int i = 0; i < 3; i++) begin
      run_store(1'b0, t_sz[i], t_a[i], t_d[i], 0, 1'b0);
      checks++;
      if (obs_timing() !== exp_timing(1'b1, 2'd0, 0, 255))
        $display("FAIL directed%0d_timing: got %h expected %h", i, obs_timing(), exp_timing(1'b1, 2'd0, 0, 255));
      else passed++;
      checks++;
      if ({obs_addr, obs_wdata, obs_be} !== {t_ma[i], t_wd[i], t_be[i]} || obs_glitch != 0)
        $display("FAIL directed%0d_data: got %h/%h/%b glitch=%0d expected %h/%h/%b glitch=0",
                 i, obs_addr, obs_wdata, obs_be, obs_glitch, t_ma[i], t_wd[i], t_be[i]);
      else passed++;
    end
  endtask

  task automatic test_errors();
    logic [1:0]  t_sz   [3] = '{2'd1, 2'd2, 2'd3};
    logic [31:0] t_a    [3] = '{32'h0000_0001, 32'h0000_0006, 32'h0000_0001};
    logic [1:0]  t_code [3] = '{2'b01, 2'b01, 2'b10};
    for (int i = 0; i < 3; i++) begin
      run_store(1'b0, t_sz[i], t_a[i], $urandom, 0, 1'b0);
      checks++;
      if (obs_timing() !== exp_timing(1'b0, t_code[i], 0, 255) || obs_glitch != 0)
        $display("FAIL error%0d: got %h glitch=%0d expected %h glitch=0",
                 i, obs_timing(), obs_glitch, exp_timing(1'b0, t_code[i], 0, 255));
      else passed++;
    end
  endtask

  task automatic test_backpressure();
    run_store(1'b0, 2'd2, 32'h0000_3008, 32'hCAFE_F00D, 5, 1'b0);
    checks++;
    if (obs_timing() !== exp_timing(1'b1, 2'd0, 5, 255))
      $display("FAIL backpressure_timing: got %h expected %h", obs_timing(), exp_timing(1'b1, 2'd0, 5, 255));
    else passed++;
    checks++;
    if ({obs_addr, obs_wdata, obs_be} !== {32'h0000_3008, 32'hCAFE_F00D, 4'hF} || obs_unstable != 0)
      $display("FAIL backpressure_data: got %h/%h/%b unstable=%0d expected 00003008/cafef00d/1111 unstable=0",
               obs_addr, obs_wdata, obs_be, obs_unstable);
    else passed++;
  endtask

  task automatic test_timeout();
    int t_delay [3] = '{100, 3, 2};
    for (int i = 0; i < 3; i++) begin
      run_store(1'b1, 2'd1, 32'h0000_0102, 32'h0000_BEEF, t_delay[i], 1'b0);
      checks++;
      if (obs_timing() !== exp_timing(1'b1, 2'd0, t_delay[i], 4) || obs_unstable != 0 || obs_glitch != 0)
        $display("FAIL timeout%0d: got %h unstable=%0d glitch=%0d expected %h",
                 i, obs_timing(), obs_unstable, obs_glitch, exp_timing(1'b1, 2'd0, t_delay[i], 4));
      else passed++;
    end
  endtask

  task automatic test_back_to_back();
    int nmv = 0, ndone = 0;
    sel = 1'b0; mem_ready = 1'b1;
    req_size = 2'd0; req_addr = 32'h0000_0011; req_data = 32'h0000_00A5; req_valid = 1'b1;
    for (int i = 0; i < 9; i++) begin
      @(posedge clk); #1;
      if (s_mem_valid) nmv++;
      if (s_done) ndone++;
    end
    req_valid = 1'b0;
    for (int i = 0; i < 6 && !s_req_ready; i++) begin
      @(posedge clk); #1;
      if (s_mem_valid) nmv++;
      if (s_done) ndone++;
    end
    mem_ready = 1'b0;
    $display("txn back_to_back : mem=%0d done=%0d", nmv, ndone);
    checks++;
    if (nmv != 3 || ndone != 3 || !s_req_ready)
      $display("FAIL back_to_back: got mem=%0d done=%0d ready=%b expected mem=3 done=3 ready=1", nmv, ndone, s_req_ready);
    else passed++;
  endtask

  task automatic test_reset_mid_mem();
    int stray = 0;
    sel = 1'b0; mem_ready = 1'b0;
    req_size = 2'd2; req_addr = 32'h0000_0040; req_data = 32'h1111_2222; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    checks++;
    if (s_mem_valid !== 1'b1) $display("FAIL midreset_enter: got mem_valid=%b expected 1", s_mem_valid);
    else passed++;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    checks++;
    if ({s_mem_valid, s_req_ready, s_busy, s_done, s_err} !== 5'b01000)
      $display("FAIL midreset_async: got %b expected 01000", {s_mem_valid, s_req_ready, s_busy, s_done, s_err});
    else passed++;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (s_done || s_err || s_mem_valid || !s_req_ready) stray++;
    end
    checks++;
    if (stray != 0) $display("FAIL midreset_stray: got %0d stray cycles expected 0", stray);
    else passed++;
    run_store(1'b0, 2'd2, 32'h0000_0080, 32'h5555_AAAA, 0, 1'b0);
    checks++;
    if (obs_timing() !== exp_timing(1'b1, 2'd0, 0, 255) ||
        {obs_addr, obs_wdata, obs_be} !== {32'h0000_0080, 32'h5555_AAAA, 4'hF})
      $display("FAIL midreset_recover: got %h %h/%h/%b expected %h 00000080/5555aaaa/1111",
               obs_timing(), obs_addr, obs_wdata, obs_be, exp_timing(1'b1, 2'd0, 0, 255));
    else passed++;
  endtask

  task automatic test_random();
    bit          ok;
    logic [1:0]  code, sz;
    logic [31:0] ea, ewd, a, d;
    logic [3:0]  ebe;
    logic        which;
    int          delay, tmo;
    for (int i = 0; i < 60; i++) begin
      which = (i % 3 == 0);
      tmo   = which ? 4 : 255;
      sz    = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      a     = $urandom;
      d     = $urandom;
      delay = $urandom_range(0, 6);
      model(sz, a, d, ok, code, ea, ewd, ebe);
      run_store(which, sz, a, d, delay, 1'($urandom_range(0, 1)));
      checks++;
      if (obs_timing() !== exp_timing(ok, code, delay, tmo) || obs_glitch != 0 || obs_unstable != 0)
        $display("FAIL random%0d_timing: got %h glitch=%0d unstable=%0d expected %h",
                 i, obs_timing(), obs_glitch, obs_unstable, exp_timing(ok, code, delay, tmo));
      else passed++;
      if (ok) begin
        checks++;
        if ({obs_addr, obs_wdata, obs_be} !== {ea, ewd, ebe})
          $display("FAIL random%0d_data: got %h/%h/%b expected %h/%h/%b",
                   i, obs_addr, obs_wdata, obs_be, ea, ewd, ebe);
        else passed++;
      end
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    rst = 1'b0;
    @(posedge clk); #1;
    test_reset();
    test_directed();
    test_errors();
    test_backpressure();
    test_timeout();
    test_back_to_back();
    test_reset_mid_mem();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit, %0d/%0d checks passed", passed, checks);
    $fatal(1);
  end

endmodule

// File: doc/store_unit.md
# store_unit

Write-side memory stage for the MIPS processor: the narrowing counterpart of the immediate/load sign extender. It accepts SB/SH/SW requests from the pipeline and checks alignment. It replicates the register data across byte lanes, generates byte enables and performs one valid/ready write transaction to data memory. Completion or error is reported back to the pipeline, which stalls on `busy`.

## Interface
Parameters:
- `TIMEOUT`, 255: max cycles `mem_valid` may wait for `mem_ready` before a bus error; legal range 1..255.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req_valid`  in  1  store request present.
- `req_ready`  out  1  unit can accept a request.
- `req_size`  in  2  00 byte, 01 half, 10 word, 11 illegal.
- `req_addr`  in  32  byte address.
- `req_data`  in  32  register value; low bits are stored.
- `mem_valid`  out  1  write request to data memory.
- `mem_ready`  in  1  memory accepts write.
- `mem_addr`  out  32  word-aligned address, `{req_addr[31:2],2'b00}`.
- `mem_wdata`  out  32  lane-replicated data.
- `mem_be`  out  4  byte enables, bit i = byte lane i (little-endian).
- `busy`  out  1  request in flight (state ≠ IDLE).
- `done`  out  1  one-cycle pulse, store completed.
- `err`  out  1  one-cycle pulse, store aborted.
- `err_code`  out  2  01 misaligned, 10 illegal size, 11 timeout; valid only with `err`.

## Operation
- States: IDLE, MEM, RESP, FAIL.
- IDLE: `req_ready`=1. Handshake = `req_valid & req_ready`. Size, address and data are captured into registers; later input changes are ignored.
- Decode at acceptance:
  - byte: `mem_wdata`={4{d[7:0]}}, `mem_be`=4'b0001<<a[1:0].
  - half: a[0] must be 0; `mem_wdata`={2{d[15:0]}}, `mem_be`= a[1] ? 1100 : 0011.
  - word: a[1:0] must be 00; `mem_wdata`=d, `mem_be`=1111.
- Illegal size has priority over misalignment. Either condition goes to FAIL and produces no memory access.
- Legal request goes to MEM. `mem_valid`=1 with addr/wdata/be held stable until `mem_valid & mem_ready`, then go to RESP.
- Timeout counter (8-bit) clears on entry to MEM and increments each MEM cycle without `mem_ready`. When the count reaches `TIMEOUT`, `mem_valid` drops and the FSM goes to FAIL with code 11. `mem_ready` in the same cycle as expiry wins: the handshake completes and there is no error.
- RESP: `done`=1 for one cycle, then IDLE.
- FAIL: `err`=1 for one cycle with `err_code`, then IDLE.
- `mem_be`, `mem_wdata` and `mem_addr` are 0 whenever `mem_valid`=0.

## Timing
- Reset (async, any state): state IDLE, counter 0. `req_ready`=1; `mem_valid`, `busy`, `done`, `err`=0; `err_code`, `mem_addr`, `mem_wdata`, `mem_be`=0.
- A reset during MEM drops `mem_valid` immediately, with no `done`/`err`.
- All outputs are registered or decoded from state only. There is no combinational path from `req_*` or `mem_ready` to any output.
- Accept at edge N. `mem_valid` is high in cycle N+1.
- Zero-wait memory: handshake at edge N+2, `done` in cycle N+2, `req_ready` high again in cycle N+3. The minimum is one store per 3 cycles.
- Error path: accept at edge N, `err` in cycle N+1, IDLE in cycle N+2.
- Timeout: `err` follows `TIMEOUT` MEM cycles without ready.
- `busy` = !`req_ready`. `req_valid` while busy is ignored; it is not queued.

## Test plan
- SB addr 0x1003, data 0x12345678, mem_ready=1 -> mem_addr 0x1000, wdata 0x78787878, be 1000, `done` 2 cycles after accept.
- SH addr 0x2002, data 0xAAAA8001 -> wdata 0x80018001, be 1100. Then SW addr 0x2004, data 0xDEADBEEF -> be 1111. Each `done` pulses once.
- Misaligned SH 0x0001, SW 0x0006, and size 11 at addr 0x0001 -> `err` codes 01, 01, 10 respectively; `mem_valid` never asserts.
- Backpressure: `mem_ready` low 5 cycles then high -> `mem_valid` held 6 cycles with stable addr/wdata/be, one `done`.
- TIMEOUT=4, `mem_ready` stuck low -> `mem_valid` for 4 cycles, then `err` code 11 and back to IDLE. Repeat with `mem_ready` rising on the 4th cycle -> `done`, no `err`.
- Assert `rst` mid-MEM -> `mem_valid` low immediately, `req_ready`=1 after release, no stray pulses, and the next SW completes normally.
